// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the IF/ID pipeline register.
// The decode stage reuses the IF/ID field widths and record layout.
package fetch_stage_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  localparam logic [PC_W-1:0]    PC_STEP          = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam logic [PC_W-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus4;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: loads a fetched record, holds it, or is flushed
// to a bubble. Flush and reset produce the same bubble record.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_load,
  input  logic   i_flush,
  input  if_id_t i_d,
  output if_id_t o_q
);

  localparam if_id_t BUBBLE = '{instr: NOP_WORD, pc: '0, pc_plus4: '0, valid: 1'b0};

  if_id_t r_q;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_q <= BUBBLE;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC selection, fetch fault
// detection and the count of instructions delivered into IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned        IMEM_BYTES = 400,
  parameter logic [INSTR_W-1:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_en,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_pc_plus4,
  output logic               if_id_valid,
  output logic               fetch_fault,
  output logic [31:0]        fetch_count
);

  logic [PC_W-1:0] r_pc;
  logic            r_fault;
  logic [31:0]     r_count;

  logic            w_pc_bad;
  logic            w_faulted;
  logic            w_load;
  logic            w_flush;
  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_pc_next;
  if_id_t          w_if_id_d;
  if_id_t          w_if_id_q;

  // Range test in 33 bits so pc near 2^32 cannot wrap into the legal window.
  assign w_pc_bad   = (r_pc[1:0] != 2'b00) ||
                      (({1'b0, r_pc} + {1'b0, PC_STEP}) > 33'(IMEM_BYTES));
  assign w_faulted  = r_fault || w_pc_bad;
  assign w_pc_plus4 = r_pc + PC_STEP;

  always_comb begin
    w_load    = 1'b0;
    w_flush   = 1'b0;
    w_pc_next = r_pc;
    if (redirect_en) begin
      w_flush   = 1'b1;
      w_pc_next = redirect_pc;
    end else if (w_faulted) begin
      w_flush   = 1'b1;
    end else if (!stall) begin
      w_load    = 1'b1;
      w_pc_next = w_pc_plus4;
    end
  end

  assign w_if_id_d = '{instr: imem_data, pc: r_pc, pc_plus4: w_pc_plus4, valid: 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
      r_count <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (redirect_en) begin
        r_fault <= 1'b0;
      end else if (w_pc_bad) begin
        r_fault <= 1'b1;
      end
      if (w_load) begin
        r_count <= r_count + 32'd1;
      end
    end
  end

  fetch_stage_if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_d     (w_if_id_d),
    .o_q     (w_if_id_q)
  );

  assign imem_addr      = r_pc;
  assign if_id_instr    = w_if_id_q.instr;
  assign if_id_pc       = w_if_id_q.pc;
  assign if_id_pc_plus4 = w_if_id_q.pc_plus4;
  assign if_id_valid    = w_if_id_q.valid;
  assign fetch_fault    = r_fault;
  assign fetch_count    = r_count;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that drives the byte address into the instruction memory and consumes its combinational 32-bit big-endian word.
- Holds the program counter and computes next-PC: sequential +4, or redirect from a later stage (branch/jump/jr).
- Registers the fetched word into the IF/ID pipeline register, with stall and flush control for the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 400, size of the instruction memory in bytes; a fetch whose last byte falls outside this range is a fault.
- NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID (load-use hazard from decode).
- redirect_en  in  1  take redirect_pc as the next PC and flush IF/ID.
- redirect_pc  in  32  redirect target byte address.
- imem_addr  out  32  byte address to instruction memory; equals pc combinationally.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- if_id_instr  out  32  registered instruction.
- if_id_pc  out  32  registered address of if_id_instr.
- if_id_pc_plus4  out  32  registered if_id_pc+4.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_fault  out  1  sticky: PC left memory range or was misaligned.
- fetch_count  out  32  number of instructions latched valid into IF/ID.

Behaviour:
- Reset (rst=1 at edge, dominates all other inputs):
  - pc=RESET_PC.
  - if_id_instr=NOP_WORD; if_id_pc=0; if_id_pc_plus4=0; if_id_valid=0.
  - fetch_fault=0; fetch_count=0.
- Latency: word at pc appears on if_id_* one edge after imem_addr=pc.
- Priority per edge: rst > redirect_en > fault > stall > normal.
- Normal:
  - pc<=pc+4, modulo 2^32 with no carry out.
  - IF/ID<={imem_data, pc, pc+4}; if_id_valid<=1; fetch_count+=1.
- Stall:
  - pc and all if_id_* hold; fetch_count holds.
- Redirect:
  - pc<=redirect_pc.
  - IF/ID<={NOP_WORD, 0, 0}; if_id_valid<=0.
  - Redirect also clears fetch_fault and overrides a simultaneous stall.
- Fault condition: pc[1:0]!=0 or pc>IMEM_BYTES-4, compared as unsigned without overflow.
  - fetch_fault<=1.
  - pc holds.
  - IF/ID<=bubble; imem_data is ignored.
  - Fault and bubbles persist until redirect or reset.
  - A redirect to a bad address faults again on the following cycle.
- Boundary cases:
  - pc=IMEM_BYTES-4 is a legal fetch; the next sequential pc faults.
  - Stall while faulted: fault behaviour applies.
- Two-state RTL: no latches, no X on outputs after reset. fetch_count wraps at 2^32.

Decomposition:
- Shared package:
  - NOP_WORD and RESET_PC defaults.
  - PC_STEP=4.
  - IF/ID field widths, reused by the decode stage.
- Natural sub-module: if_id_reg. It holds the instr/pc/pc_plus4/valid flops with load, hold and flush controls.
- PC, next-PC mux, fault logic and counter stay in fetch_stage.

Test Plan:
- Reset, then 3 free-running cycles with imem_data=A,B,C at pc 0,4,8:
  - if_id sequence (A,0,4,v1), (B,4,8,v1), (C,8,12,v1).
  - fetch_count=3.
- Stall for 2 cycles at pc=8:
  - imem_addr stays 8; if_id holds (B,4,8); fetch_count unchanged.
  - Release: next edge latches word at 8.
- redirect_en with redirect_pc=0x40, asserted together with stall:
  - next edge pc=0x40, if_id_valid=0, if_id_instr=0.
  - Following edge latches the word at 0x40 with valid=1.
- Run to pc=396 (IMEM_BYTES=400):
  - 396 is latched valid; pc becomes 400.
  - Next edge fetch_fault=1, valid=0, pc stays 400.
  - redirect to 0 clears the fault.
- redirect_pc=0x2:
  - next edge fetch_fault=1, bubble, pc stays 0x2.
- Assert rst mid-stall after a fault:
  - all outputs return to reset values (pc=0, fault=0, count=0) on that edge.
